// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for the 5-stage RV32I core. It captures the
//   register-file read data, the immediate and the decoded control from ID and
//   presents them to EX one cycle later. It also detects load-use hazards,
//   bypasses the WB write into the captured operands, inserts bubbles on
//   load-use stalls and branch flushes, and counts the bubbles it inserts.
//
// Ports
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   id_valid                 ID holds a real instruction
//   id_pc, id_imm            PC and sign-extended immediate of the ID instruction
//   id_rs1, id_rs2, id_rd    source / destination register indices
//   id_rdata1, id_rdata2     register-file read data
//   id_ctrl                  {reg_write,mem_read,mem_write,mem_to_reg,alu_src,alu_op[3:0]}
//   wb_reg_write, wb_rd,
//   wb_data                  register-file write port of the WB stage
//   ex_flush                 taken branch/jump in EX; kill the ID instruction
//   ex_*                     registered copies of the ID fields for EX
//   stall_id                 combinational: hold PC and IF/ID this cycle
//   bubble_cnt               saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [8:0]       id_ctrl,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [8:0]       ex_ctrl,
  output logic             stall_id,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int MEM_READ_BIT = 7;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // WB writes the register file in the same cycle ID reads it, so the read
  // data can be stale; take the WB value instead. x0 is never bypassed.
  function automatic logic [XLEN-1:0] bypass(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rdata,
    input logic            wr_en,
    input logic [4:0]      wr_rd,
    input logic [XLEN-1:0] wr_data
  );
    return (wr_en && (wr_rd != 5'd0) && (wr_rd == rs)) ? wr_data : rdata;
  endfunction

  logic insert_bubble;

  // Conservative: both rs fields are compared whatever the instruction format.
  assign stall_id = ex_valid && ex_ctrl[MEM_READ_BIT] && (ex_rd != 5'd0) && id_valid &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // A flush overrides a stall; either one produces exactly one bubble.
  assign insert_bubble = ex_flush || stall_id;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_ctrl    <= '0;
      bubble_cnt <= '0;
    end else if (insert_bubble) begin
      // Bubble: clear valid and control so nothing is written; data fields hold.
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      bubble_cnt <= sat_inc(bubble_cnt);
    end else begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_imm   <= id_imm;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_op1   <= bypass(id_rs1, id_rdata1, wb_reg_write, wb_rd, wb_data);
      ex_op2   <= bypass(id_rs2, id_rdata2, wb_reg_write, wb_rd, wb_data);
      ex_ctrl  <= id_valid ? id_ctrl : 9'd0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_imm, id_rdata1, id_rdata2, wb_data;
  logic [4:0]       id_rs1, id_rs2, id_rd, wb_rd;
  logic [8:0]       id_ctrl;
  logic             wb_reg_write, ex_flush, flush2;
  logic             no_valid = 1'b0;

  logic             ex_valid, stall_id;
  logic [XLEN-1:0]  ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [8:0]       ex_ctrl;
  logic [31:0]      bubble_cnt;

  logic             d2_valid, d2_stall;
  logic [XLEN-1:0]  d2_pc, d2_imm, d2_op1, d2_op2;
  logic [4:0]       d2_rs1, d2_rs2, d2_rd;
  logic [8:0]       d2_ctrl;
  logic [3:0]       d2_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_ctrl(ex_ctrl),
    .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter build used only for the saturation check; never sees a valid
  // instruction, so its only bubbles come from flush2.
  id_ex_stage #(.XLEN(XLEN), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(no_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(flush2),
    .ex_valid(d2_valid), .ex_pc(d2_pc), .ex_imm(d2_imm), .ex_rs1(d2_rs1), .ex_rs2(d2_rs2),
    .ex_rd(d2_rd), .ex_op1(d2_op1), .ex_op2(d2_op2), .ex_ctrl(d2_ctrl),
    .stall_id(d2_stall), .bubble_cnt(d2_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // What EX must hold: the last instruction that was allowed through, or an
  // empty slot after a kill. Counts are plain integers clamped at the maximum.
  logic            m_valid;
  logic [XLEN-1:0] m_pc, m_imm, m_op1, m_op2;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [8:0]      m_ctrl;
  longint          m_cnt, m_cnt4;

  function automatic bit load_use();
    return m_valid && m_ctrl[7] && (m_rd != 0) && id_valid &&
           ((m_rd == id_rs1) || (m_rd == id_rs2));
  endfunction

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] rs, input logic [XLEN-1:0] rd_data);
    if (wb_reg_write && wb_rd == rs && rs != 0) return wb_data;
    return rd_data;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_pc <= 0; m_imm <= 0; m_op1 <= 0; m_op2 <= 0;
      m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_ctrl <= 0; m_cnt <= 0; m_cnt4 <= 0;
    end else begin
      if (ex_flush || load_use()) begin
        m_valid <= 0;
        m_ctrl  <= 0;
        m_cnt   <= (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
      end else begin
        m_valid <= id_valid;
        m_pc <= id_pc; m_imm <= id_imm;
        m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd;
        m_op1 <= rf_read(id_rs1, id_rdata1);
        m_op2 <= rf_read(id_rs2, id_rdata2);
        m_ctrl <= id_valid ? id_ctrl : 9'd0;
      end
      if (flush2) m_cnt4 <= (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.ex_valid", ex_valid, m_valid);
      chk("m.ex_pc",    ex_pc,    m_pc);
      chk("m.ex_imm",   ex_imm,   m_imm);
      chk("m.ex_rs1",   ex_rs1,   m_rs1);
      chk("m.ex_rs2",   ex_rs2,   m_rs2);
      chk("m.ex_rd",    ex_rd,    m_rd);
      chk("m.ex_op1",   ex_op1,   m_op1);
      chk("m.ex_op2",   ex_op2,   m_op2);
      chk("m.ex_ctrl",  ex_ctrl,  m_ctrl);
      chk("m.stall_id", stall_id, load_use());
      chk("m.bubble_cnt", bubble_cnt, m_cnt);
      chk("m.cnt4",     d2_cnt,   m_cnt4);
      chk("m.d2_valid", d2_valid, 1'b0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [8:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_ctrl = ctrl;
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 9'h0);
    wb_reg_write = 0; wb_rd = 0; wb_data = 0; ex_flush = 0; flush2 = 0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst.ex_valid", ex_valid, 0);
    chk("rst.bubble_cnt", bubble_cnt, 0);
    rst_n = 1'b1;
    step();

    // Pass-through
    set_id(1, 32'h40, 5'd1, 5'd0, 5'd2, 32'd1, 32'd0, 32'd8, 9'h100);
    step();
    chk("pass.ex_pc", ex_pc, 32'h40);
    chk("pass.ex_op1", ex_op1, 32'd1);
    chk("pass.ex_imm", ex_imm, 32'd8);
    chk("pass.ex_ctrl", ex_ctrl, 9'h100);
    chk("pass.ex_valid", ex_valid, 1);

    // Load-use: lw x5 then add x7,x6,x5
    set_id(1, 32'h44, 5'd1, 5'd0, 5'd5, 32'h10, 32'd0, 32'd4, 9'h1A0);
    step();
    set_id(1, 32'h48, 5'd6, 5'd5, 5'd7, 32'h66, 32'h55, 32'd0, 9'h100);
    #1;
    chk("lu.stall", stall_id, 1);
    step();
    chk("lu.bubble_valid", ex_valid, 0);
    chk("lu.bubble_ctrl", ex_ctrl, 9'h0);
    chk("lu.bubble_pc_hold", ex_pc, 32'h44);
    chk("lu.cnt", bubble_cnt, 1);
    chk("lu.stall_released", stall_id, 0);
    step();
    chk("lu.add_pc", ex_pc, 32'h48);
    chk("lu.add_valid", ex_valid, 1);
    chk("lu.add_op2", ex_op2, 32'h55);

    // Bypass on op1, then x0 never bypassed, then bypass on op2
    wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    set_id(1, 32'h4C, 5'd3, 5'd9, 5'd4, 32'd0, 32'h99, 32'd0, 9'h100);
    step();
    chk("byp.op1", ex_op1, 32'hDEAD);
    chk("byp.op2_nomatch", ex_op2, 32'h99);
    wb_rd = 5'd0;
    set_id(1, 32'h50, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'd0, 9'h100);
    step();
    chk("byp.x0", ex_op1, 32'd0);
    wb_rd = 5'd9; wb_data = 32'h1234_5678;
    set_id(1, 32'h54, 5'd1, 5'd9, 5'd4, 32'h11, 32'h0, 32'd0, 9'h110);
    step();
    chk("byp.op2", ex_op2, 32'h1234_5678);
    chk("byp.op1_nomatch", ex_op1, 32'h11);
    wb_reg_write = 0;

    // Invalid ID: slot empty, control zero, no count
    set_id(0, 32'h58, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 9'h1FF);
    step();
    chk("inv.valid", ex_valid, 0);
    chk("inv.ctrl", ex_ctrl, 9'h0);
    chk("inv.cnt", bubble_cnt, 1);

    // Flush coincident with load-use: one bubble only
    set_id(1, 32'h5C, 5'd2, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0, 9'h1A0);
    step();
    set_id(1, 32'h60, 5'd5, 5'd1, 5'd8, 32'd7, 32'd0, 32'd0, 9'h100);
    ex_flush = 1;
    #1;
    chk("fs.stall", stall_id, 1);
    step();
    ex_flush = 0;
    chk("fs.cnt", bubble_cnt, 2);
    chk("fs.valid", ex_valid, 0);
    step();
    chk("fs.after_pc", ex_pc, 32'h60);
    chk("fs.after_valid", ex_valid, 1);

    // Saturation on the 4-bit counter build
    flush2 = 1;
    for (int i = 0; i < 3; i++) step();
    chk("sat.cnt3", d2_cnt, 4'd3);
    for (int i = 0; i < 17; i++) step();
    flush2 = 0;
    chk("sat.hold", d2_cnt, 4'hF);
    step();
    chk("sat.still", d2_cnt, 4'hF);

    // Reset mid-run with a load in EX: clears without a clock edge
    set_id(1, 32'h64, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0, 32'd4, 9'h1A0);
    step();
    set_id(1, 32'h68, 5'd5, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 9'h100);
    #1;
    chk("mr.pre_valid", ex_valid, 1);
    chk("mr.pre_stall", stall_id, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr.valid", ex_valid, 0);
    chk("mr.pc", ex_pc, 0);
    chk("mr.imm", ex_imm, 0);
    chk("mr.rd", ex_rd, 0);
    chk("mr.ctrl", ex_ctrl, 0);
    chk("mr.cnt", bubble_cnt, 0);
    chk("mr.cnt4", d2_cnt, 0);
    chk("mr.stall", stall_id, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mr.after_pc", ex_pc, 32'h68);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
